// File: rtl/gcd_arb_pkg.sv
// Shared types and constants for the GCD engine arbiter.
// Widths of the operand/result path and the saturating engine-latency counter.
package gcd_arb_pkg;
    localparam int OP_W  = 16;
    localparam int IN_W  = 32;
    localparam int CYC_W = 17;

    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (v == CYC_MAX) ? v : v + CYC_W'(1);
    endfunction
endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester-fabric and engine-side bundle of the arbiter.
// master = the fabric/engine environment, slave = the arbiter.
interface gcd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import gcd_arb_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [IN_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      resp_valid;
    logic [NUM_REQ-1:0]      resp_ready;
    logic [OP_W-1:0]         resp_data;
    logic [CYC_W-1:0]        resp_cycles;
    logic                    gcd_in_valid;
    logic [IN_W-1:0]         gcd_in_data;
    logic                    gcd_in_ready;
    logic                    gcd_out_valid;
    logic [OP_W-1:0]         gcd_out_data;

    modport master (
        output req_valid, req_data, resp_ready, gcd_in_ready, gcd_out_valid, gcd_out_data,
        input  req_ready, resp_valid, resp_data, resp_cycles, gcd_in_valid, gcd_in_data
    );

    modport slave (
        input  req_valid, req_data, resp_ready, gcd_in_ready, gcd_out_valid, gcd_out_data,
        output req_ready, resp_valid, resp_data, resp_cycles, gcd_in_valid, gcd_in_data
    );
endinterface

// File: rtl/gcd_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_picker
    import gcd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);
    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one GCD engine among NUM_REQ requesters.
// One job in flight; the result is held until the owning requester accepts it.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            reset,
    gcd_arbiter_if.slave    bus,
    output logic            busy,
    output logic [ID_W-1:0] grant_id
);
    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    last_grant;
    logic [IN_W-1:0]    operand;
    logic [CYC_W-1:0]   counter;
    logic [OP_W-1:0]    resp_data_q;
    logic [CYC_W-1:0]   resp_cycles_q;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_id;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (pick_onehot),
        .grant_id   (pick_id)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|bus.req_valid)             state_next = ISSUE;
            ISSUE:   if (bus.gcd_in_ready)           state_next = RUN;
            RUN:     if (bus.gcd_out_valid)          state_next = RESP;
            RESP:    if (bus.resp_ready[grant_id])   state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    // last_grant starts at NUM_REQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant    <= ID_W'(NUM_REQ - 1);
            grant_id      <= '0;
            operand       <= '0;
            counter       <= '0;
            resp_data_q   <= '0;
            resp_cycles_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        grant_id <= pick_id;
                        operand  <= bus.req_data[int'(pick_id)*IN_W +: IN_W];
                    end
                end
                ISSUE: begin
                    if (bus.gcd_in_ready) begin
                        counter <= '0;
                    end
                end
                RUN: begin
                    counter <= sat_inc(counter);
                    if (bus.gcd_out_valid) begin
                        resp_data_q   <= bus.gcd_out_data;
                        resp_cycles_q <= sat_inc(counter);
                    end
                end
                RESP: begin
                    if (bus.resp_ready[grant_id]) begin
                        last_grant <= grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // req_ready is masked while reset is held so nothing appears accepted during reset.
    always_comb begin
        bus.req_ready    = '0;
        bus.resp_valid   = '0;
        bus.gcd_in_valid = 1'b0;
        busy             = 1'b0;
        case (state)
            IDLE: begin
                if (reset) begin
                    bus.req_ready = pick_onehot;
                end
            end
            ISSUE: begin
                bus.gcd_in_valid = 1'b1;
                busy             = 1'b1;
            end
            RUN: begin
                busy = 1'b1;
            end
            RESP: begin
                bus.resp_valid[grant_id] = 1'b1;
                busy                     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.gcd_in_data = operand;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_cycles = resp_cycles_q;
endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter with a behavioural subtract-and-swap GCD engine
// and a round-robin/GCD reference model.
module tb_gcd_arbiter;
    import gcd_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic           busy;
    logic [IDW-1:0] grant_id;

    gcd_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    gcd_arbiter #(
        .NUM_REQ (NREQ),
        .ID_W    (IDW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    int n_tests    = 0;
    int n_fail     = 0;
    int model_last = NREQ - 1;

    logic        eng_busy   = 1'b0;
    int          eng_left   = 0;
    logic [15:0] eng_res    = '0;
    logic        eng_stall  = 1'b0;
    logic        stall_en   = 1'b0;
    logic        spur_valid = 1'b0;
    logic [15:0] spur_data  = '0;

    always #5 clk = ~clk;

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine latency: one cycle per subtract or swap step, plus the cycle that emits the result.
    function automatic int eng_steps(input int a, input int b);
        int n;
        int t;
        n = 1;
        while (a != 0 && b != 0) begin
            if (a < b) begin
                t = a;
                a = b;
                b = t;
            end else begin
                a = a - b;
            end
            n++;
        end
        return n;
    endfunction

    function automatic int rr_expect(input logic [NREQ-1:0] mask, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (mask[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    assign bus.gcd_in_ready  = !eng_busy && !eng_stall;
    assign bus.gcd_out_valid = (eng_busy && eng_left == 1) || spur_valid;
    assign bus.gcd_out_data  = spur_valid ? spur_data : eng_res;

    always @(posedge clk) begin
        if (!reset) begin
            eng_busy <= 1'b0;
        end else if (eng_busy) begin
            if (eng_left == 1) eng_busy <= 1'b0;
            else               eng_left <= eng_left - 1;
        end else if (bus.gcd_in_valid && bus.gcd_in_ready) begin
            eng_busy <= 1'b1;
            eng_left <= eng_steps(int'(bus.gcd_in_data[31:16]), int'(bus.gcd_in_data[15:0]));
            eng_res  <= 16'(gcd_ref(int'(bus.gcd_in_data[31:16]), int'(bus.gcd_in_data[15:0])));
        end
    end

    always @(negedge clk) eng_stall <= stall_en && ($urandom_range(0, 3) == 0);

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        spur_valid     = 1'b0;
        stall_en       = 1'b0;
        tick();
        tick();
        reset      = 1'b1;
        model_last = NREQ - 1;
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid[id]       = 1'b1;
        bus.req_data[id*32 +: 32] = {a, b};
    endtask

    task automatic wait_ready(output int idx, output bit to);
        idx = -1;
        to  = 1'b1;
        #1;
        for (int n = 0; n < 200; n++) begin
            if (bus.req_ready != '0) begin
                for (int k = 0; k < NREQ; k++) if (bus.req_ready[k] && idx < 0) idx = k;
                to = 1'b0;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_resp(input int id, inout int lat, output bit to);
        to = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (bus.resp_valid[id]) begin
                to = 1'b0;
                return;
            end
            tick();
            lat++;
        end
    endtask

    task automatic accept_resp(input int id);
        bus.resp_ready[id] = 1'b1;
        tick();
        bus.resp_ready[id] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_req(1, 16'd5, 16'd3);
        tick();
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        n_tests++; if (bus.resp_valid !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_resp_valid: got %b want 0000", bus.resp_valid); end
        n_tests++; if (bus.gcd_in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_valid: got %b want 0", bus.gcd_in_valid); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_tests++; if (bus.resp_data !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_resp_data: got %0d want 0", bus.resp_data); end
        n_tests++; if (bus.resp_cycles !== 17'd0) begin n_fail++; $display("[TB] FAIL reset_resp_cycles: got %0d want 0", bus.resp_cycles); end
        n_tests++; if (bus.gcd_in_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_in_data: got %h want 0", bus.gcd_in_data); end
        bus.req_valid = '0;
        reset         = 1'b1;
        model_last    = NREQ - 1;
        tick();
    endtask

    task automatic test_single();
        int idx, lat;
        bit to;
        do_reset();
        set_req(0, 16'd0, 16'd7);
        wait_ready(idx, to);
        n_tests++; if (to || idx != 0) begin n_fail++; $display("[TB] FAIL single_grant: got %0d want 0 (timeout %0d)", idx, to); end
        n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_ready_onehot: got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        lat = 1;
        #1;
        n_tests++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("[TB] FAIL single_ready_pulse: got %b want 0000", bus.req_ready); end
        n_tests++; if (bus.gcd_in_valid !== 1'b1 || bus.gcd_in_data !== 32'h0000_0007) begin n_fail++; $display("[TB] FAIL single_issue: got valid %b data %h want 1 00000007", bus.gcd_in_valid, bus.gcd_in_data); end
        wait_resp(0, lat, to);
        n_tests++; if (to || lat != 3) begin n_fail++; $display("[TB] FAIL single_latency: got %0d want 3 (timeout %0d)", lat, to); end
        n_tests++; if (bus.resp_data !== 16'd7) begin n_fail++; $display("[TB] FAIL single_data: got %0d want 7", bus.resp_data); end
        n_tests++; if (bus.resp_cycles !== 17'd1) begin n_fail++; $display("[TB] FAIL single_cycles: got %0d want 1", bus.resp_cycles); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.resp_valid !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_hold: got %b want 0001", bus.resp_valid); end
        end
        accept_resp(0);
        model_last = 0;
        n_tests++; if (bus.resp_valid !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_release: got resp_valid %b busy %b want 0000 0", bus.resp_valid, busy); end
    endtask

    task automatic test_iterative();
        int idx, lat;
        bit to;
        do_reset();
        set_req(2, 16'd12, 16'd8);
        wait_ready(idx, to);
        n_tests++; if (to || idx != 2) begin n_fail++; $display("[TB] FAIL iter_grant: got %0d want 2 (timeout %0d)", idx, to); end
        tick();
        bus.req_valid[2] = 1'b0;
        lat = 1;
        wait_resp(2, lat, to);
        n_tests++; if (to || lat != 2 + eng_steps(12, 8)) begin n_fail++; $display("[TB] FAIL iter_latency: got %0d want %0d", lat, 2 + eng_steps(12, 8)); end
        n_tests++; if (grant_id !== 2'd2) begin n_fail++; $display("[TB] FAIL iter_grant_id: got %0d want 2", grant_id); end
        n_tests++; if (bus.resp_data !== 16'd4) begin n_fail++; $display("[TB] FAIL iter_data: got %0d want 4", bus.resp_data); end
        n_tests++; if (bus.resp_cycles !== 17'd5) begin n_fail++; $display("[TB] FAIL iter_cycles: got %0d want 5", bus.resp_cycles); end
        accept_resp(2);
    endtask

    task automatic test_fairness();
        int pa[NREQ];
        int pb[NREQ];
        int cnt[NREQ];
        int idx, lat, mx, mn;
        bit to;
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            pa[r]  = $urandom_range(1, 40);
            pb[r]  = $urandom_range(1, 40);
            cnt[r] = 0;
            set_req(r, 16'(pa[r]), 16'(pb[r]));
        end
        for (int j = 0; j < 6; j++) begin
            wait_ready(idx, to);
            n_tests++; if (to || idx != j % NREQ) begin n_fail++; $display("[TB] FAIL fair_order[%0d]: got %0d want %0d", j, idx, j % NREQ); end
            if (to) break;
            cnt[idx]++;
            mx = cnt[0];
            mn = cnt[0];
            for (int r = 1; r < NREQ; r++) begin
                if (cnt[r] > mx) mx = cnt[r];
                if (cnt[r] < mn) mn = cnt[r];
            end
            n_tests++; if (mx - mn > 1) begin n_fail++; $display("[TB] FAIL fair_balance[%0d]: got spread %0d want <=1", j, mx - mn); end
            tick();
            lat = 1;
            wait_resp(idx, lat, to);
            n_tests++; if (to || bus.resp_data !== 16'(gcd_ref(pa[idx], pb[idx]))) begin n_fail++; $display("[TB] FAIL fair_data[%0d]: got %0d want %0d", j, bus.resp_data, gcd_ref(pa[idx], pb[idx])); end
            pa[idx] = $urandom_range(1, 40);
            pb[idx] = $urandom_range(1, 40);
            set_req(idx, 16'(pa[idx]), 16'(pb[idx]));
            accept_resp(idx);
            model_last = idx;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        int idx, lat;
        bit to;
        do_reset();
        set_req(1, 16'd9, 16'd6);
        wait_ready(idx, to);
        tick();
        bus.req_valid[1] = 1'b0;
        lat = 1;
        wait_resp(1, lat, to);
        n_tests++; if (to) begin n_fail++; $display("[TB] FAIL bp_resp: got timeout want resp_valid[1]"); end
        set_req(3, 16'd5, 16'd10);
        bus.resp_ready[0] = 1'b1;
        bus.resp_ready[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++; if (bus.resp_data !== 16'd3 || bus.resp_cycles !== 17'(eng_steps(9, 6))) begin n_fail++; $display("[TB] FAIL bp_stable[%0d]: got %0d/%0d want 3/%0d", i, bus.resp_data, bus.resp_cycles, eng_steps(9, 6)); end
            n_tests++; if (bus.req_ready !== 4'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_idle_out[%0d]: got req_ready %b busy %b want 0000 1", i, bus.req_ready, busy); end
            n_tests++; if (bus.resp_valid !== 4'b0010) begin n_fail++; $display("[TB] FAIL bp_resp_valid[%0d]: got %b want 0010", i, bus.resp_valid); end
        end
        bus.resp_ready    = '0;
        bus.resp_ready[1] = 1'b1;
        #1;
        n_tests++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("[TB] FAIL bp_no_accept_in_resp: got %b want 0000", bus.req_ready); end
        tick();
        bus.resp_ready[1] = 1'b0;
        model_last = 1;
        #1;
        n_tests++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL bp_next_grant: got %b want 1000", bus.req_ready); end
        wait_ready(idx, to);
        tick();
        bus.req_valid[3] = 1'b0;
        lat = 1;
        wait_resp(3, lat, to);
        n_tests++; if (to || bus.resp_data !== 16'd5) begin n_fail++; $display("[TB] FAIL bp_second_data: got %0d want 5", bus.resp_data); end
        accept_resp(3);
    endtask

    task automatic test_spurious();
        int idx, lat;
        bit to;
        do_reset();
        spur_valid = 1'b1;
        spur_data  = 16'hBEEF;
        tick();
        spur_valid = 1'b0;
        n_tests++; if (busy !== 1'b0 || bus.resp_valid !== 4'b0) begin n_fail++; $display("[TB] FAIL spur_idle_state: got busy %b resp_valid %b want 0 0000", busy, bus.resp_valid); end
        n_tests++; if (bus.resp_data !== 16'd0 || bus.resp_cycles !== 17'd0) begin n_fail++; $display("[TB] FAIL spur_idle_data: got %h/%0d want 0/0", bus.resp_data, bus.resp_cycles); end
        set_req(2, 16'd21, 16'd14);
        wait_ready(idx, to);
        tick();
        bus.req_valid[2] = 1'b0;
        lat = 1;
        wait_resp(2, lat, to);
        spur_valid = 1'b1;
        spur_data  = 16'h1234;
        tick();
        spur_valid = 1'b0;
        tick();
        n_tests++; if (bus.resp_data !== 16'd7 || bus.resp_cycles !== 17'(eng_steps(21, 14))) begin n_fail++; $display("[TB] FAIL spur_resp_data: got %0d/%0d want 7/%0d", bus.resp_data, bus.resp_cycles, eng_steps(21, 14)); end
        n_tests++; if (bus.resp_valid !== 4'b0100 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_resp_state: got %b busy %b want 0100 1", bus.resp_valid, busy); end
        accept_resp(2);
    endtask

    task automatic test_mid_run_reset();
        int idx, lat;
        bit to;
        do_reset();
        set_req(2, 16'd200, 16'd3);
        wait_ready(idx, to);
        tick();
        bus.req_valid[2] = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b1 || bus.gcd_in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mrr_in_run: got busy %b in_valid %b want 1 0", busy, bus.gcd_in_valid); end
        reset = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0 || bus.req_ready !== 4'b0 || bus.resp_valid !== 4'b0 || bus.gcd_in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mrr_ctrl: got busy %b rr %b rv %b iv %b want all 0", busy, bus.req_ready, bus.resp_valid, bus.gcd_in_valid); end
        n_tests++; if (grant_id !== 2'd0 || bus.resp_data !== 16'd0 || bus.resp_cycles !== 17'd0 || bus.gcd_in_data !== 32'd0) begin n_fail++; $display("[TB] FAIL mrr_regs: got gid %0d rd %0d rc %0d id %h want all 0", grant_id, bus.resp_data, bus.resp_cycles, bus.gcd_in_data); end
        reset      = 1'b1;
        model_last = NREQ - 1;
        set_req(1, 16'd35, 16'd21);
        set_req(0, 16'd18, 16'd12);
        wait_ready(idx, to);
        n_tests++; if (to || idx != 0) begin n_fail++; $display("[TB] FAIL mrr_first_grant: got %0d want 0", idx); end
        tick();
        bus.req_valid[0] = 1'b0;
        lat = 1;
        wait_resp(0, lat, to);
        n_tests++; if (to || bus.resp_data !== 16'd6) begin n_fail++; $display("[TB] FAIL mrr_data0: got %0d want 6", bus.resp_data); end
        accept_resp(0);
        wait_ready(idx, to);
        n_tests++; if (to || idx != 1) begin n_fail++; $display("[TB] FAIL mrr_second_grant: got %0d want 1", idx); end
        tick();
        bus.req_valid[1] = 1'b0;
        lat = 1;
        wait_resp(1, lat, to);
        n_tests++; if (to || bus.resp_data !== 16'd7) begin n_fail++; $display("[TB] FAIL mrr_data1: got %0d want 7", bus.resp_data); end
        accept_resp(1);
    endtask

    task automatic test_random();
        int pa[NREQ];
        int pb[NREQ];
        logic [NREQ-1:0] mask;
        int idx, exp_id, lat, r0;
        bit to;
        do_reset();
        stall_en = 1'b1;
        mask     = '0;
        for (int j = 0; j < 24; j++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!mask[r] && $urandom_range(0, 1) == 1) begin
                    pa[r] = $urandom_range(0, 60);
                    pb[r] = $urandom_range(0, 60);
                    set_req(r, 16'(pa[r]), 16'(pb[r]));
                    mask[r] = 1'b1;
                end
            end
            if (mask == '0) begin
                r0     = $urandom_range(0, NREQ - 1);
                pa[r0] = $urandom_range(0, 60);
                pb[r0] = $urandom_range(0, 60);
                set_req(r0, 16'(pa[r0]), 16'(pb[r0]));
                mask[r0] = 1'b1;
            end
            exp_id = rr_expect(mask, model_last);
            wait_ready(idx, to);
            n_tests++; if (to || idx != exp_id) begin n_fail++; $display("[TB] FAIL rand_grant[%0d]: got %0d want %0d (mask %b)", j, idx, exp_id, mask); end
            if (to) break;
            n_tests++; if ($countones(bus.req_ready) != 1) begin n_fail++; $display("[TB] FAIL rand_ready_onehot[%0d]: got %b want one bit", j, bus.req_ready); end
            tick();
            bus.req_valid[idx] = 1'b0;
            mask[idx]          = 1'b0;
            lat = 1;
            wait_resp(idx, lat, to);
            n_tests++; if (to || bus.resp_data !== 16'(gcd_ref(pa[idx], pb[idx])) || bus.resp_cycles !== 17'(eng_steps(pa[idx], pb[idx]))) begin n_fail++; $display("[TB] FAIL rand_result[%0d]: got %0d/%0d want %0d/%0d", j, bus.resp_data, bus.resp_cycles, gcd_ref(pa[idx], pb[idx]), eng_steps(pa[idx], pb[idx])); end
            if (to) break;
            repeat ($urandom_range(0, 3)) tick();
            n_tests++; if (bus.resp_valid !== NREQ'(1 << idx)) begin n_fail++; $display("[TB] FAIL rand_resp_valid[%0d]: got %b want bit %0d", j, bus.resp_valid, idx); end
            accept_resp(idx);
            model_last = idx;
        end
        stall_en      = 1'b0;
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = '0;
        test_reset();
        test_single();
        test_iterative();
        test_fairness();
        test_backpressure();
        test_spurious();
        test_mid_run_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin scheduler that shares one GCD engine among `NUM_REQ` requesters. The engine accepts one job at a time, and its result is a single-cycle pulse with no backpressure. This block arbitrates requests, issues one job to the engine, captures the engine result, and holds it until the owning requester accepts it. It also reports how many cycles the engine took. It sits between the requester fabric and the single engine instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..16).
- `ID_W`, `$clog2(NUM_REQ)`: grant index width.

Ports:
- `clk`  in  1  clock. Everything is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester job valid. Must stay high, with data stable, until ready.
- `req_data`  in  32*NUM_REQ  per-requester operands. Slice `i` is `[32*i+31:32*i]`; a=`[31:16]`, b=`[15:0]`.
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `resp_valid`  out  NUM_REQ  one-hot result valid, held until accepted.
- `resp_ready`  in  NUM_REQ  per-requester result accept.
- `resp_data`  out  16  GCD result. Shared; qualified by `resp_valid`.
- `resp_cycles`  out  17  engine latency of this job. Shared.
- `gcd_in_valid`  out  1  job valid to the engine.
- `gcd_in_data`  out  32  `{a,b}` to the engine.
- `gcd_in_ready`  in  1  engine idle.
- `gcd_out_valid`  in  1  engine result pulse, one cycle.
- `gcd_out_data`  in  16  engine result.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  ID_W  index of the current owner. Holds the last owner while IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, RUN, RESP.
- **IDLE:**
  - If any `req_valid` is high, pick winner `g` by round-robin, searching from `last_grant+1` mod `NUM_REQ` upward.
  - Drive `req_ready[g]=1` combinationally for that cycle only.
  - Latch `req_data[g]` into the operand register and `g` into `grant_id`, then go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE:**
  - `gcd_in_valid=1` and `gcd_in_data`=operand register.
  - On `gcd_in_ready`, this is the handshake: clear the cycle counter to 0 and go to RUN.
- **RUN:**
  - The counter increments every cycle and saturates at 2^17−1.
  - On `gcd_out_valid`, latch `gcd_out_data` into `resp_data` and counter+1 into `resp_cycles`, then go to RESP.
- **RESP:**
  - `resp_valid[grant_id]=1`.
  - On `resp_ready[grant_id]`, set `last_grant<=grant_id` and go to IDLE.
  - `resp_ready` on any other index is ignored.
- Exactly one job is outstanding at a time. A new request is not accepted in the RESP cycle that completes; the earliest new accept is the following IDLE cycle.
- `gcd_out_valid` outside RUN is ignored (no state change, no output effect).
- Operand values are passed through unmodified; zero operands are legal.

## Timing
- Reset (`reset==0` at a rising edge): state=IDLE, `last_grant=NUM_REQ-1` so requester 0 has first priority.
  - The counter, operand register, `resp_data`, `resp_cycles` and `grant_id` all clear to 0.
  - All `*_ready`, `*_valid` and `busy` outputs are 0.
- Reset mid-job abandons the job with no response. The engine shares this reset, inverted at the top level.
- Request accepted at cycle T: `gcd_in_valid` goes high at T+1. With the engine idle, the handshake is at T+1.
- `resp_valid` rises the cycle after `gcd_out_valid`.
- Minimum request-to-response latency is T+3: accept, issue, one engine cycle, then `resp_valid`.
- `req_ready` is never high for more than one requester, and never high outside IDLE.
- `resp_valid` is never high for more than one requester, and never high outside RESP.

## Structure
- Shared package `gcd_arb_pkg`:
  - state enum {IDLE, ISSUE, RUN, RESP};
  - `OP_W=16`, `IN_W=32`, `CYC_W=17`;
  - counter saturation constant.
- One sub-module, `rr_picker`:
  - inputs: request vector and `last_grant`;
  - outputs: one-hot grant and grant index, combinational.
- FSM, counter and registers live in `gcd_arbiter`.

## Test plan
- **Single request:** requester 0 sends a=0, b=7 → `req_ready[0]` for one cycle, `resp_data`=7, `resp_cycles`=1, `resp_valid[0]` held until `resp_ready[0]`.
- **Iterative job:** requester 2 sends a=12, b=8 → `resp_data`=4, `resp_cycles`=5, `grant_id`=2.
- **Fairness:** all four requesters hold valid continuously → grant order 0,1,2,3,0,1, and no requester is granted twice before all others are granted once.
- **Response backpressure:** `resp_ready` is held low for 10 cycles after `resp_valid` → `resp_data` and `resp_cycles` stay stable, no `req_ready` asserts, and `busy`=1 throughout.
- **Spurious engine pulse:** `gcd_out_valid` is forced in IDLE, then in RESP → no output change, and the held result is unchanged.
- **Mid-RUN reset:** `reset` is driven low while in RUN → the next cycle shows all outputs 0 and state IDLE; the next request from requester 0 is granted first.
